// File: rtl/processor_pkg.sv
// Definitions shared by the processor datapath and the operand issuer feeding it.
package processor_pkg;

    localparam int unsigned DEFAULT_WORDSIZE = 64;
    localparam int unsigned PROC_SEQ_LEN     = 7;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE,
        HOLD
    } issuer_state_e;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO of operand/operation entries with occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module operand_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/operand_issuer.sv
// Buffers operand requests and presents each one, held stable, for a full
// processor sequence; issue marks the first cycle of every hold window.
module operand_issuer
    import processor_pkg::*;
#(
    parameter int unsigned WORDSIZE    = DEFAULT_WORDSIZE,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = PROC_SEQ_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDSIZE-1:0]     in_num1,
    input  logic [WORDSIZE-1:0]     in_num2,
    input  logic                    in_operation,
    output logic [WORDSIZE-1:0]     num1,
    output logic [WORDSIZE-1:0]     num2,
    output logic                    operation_out,
    output logic                    issue,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned ENTRY_W = 2 * WORDSIZE + 1;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    issuer_state_e        state_q, state_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [WORDSIZE-1:0]  num1_q, num1_d;
    logic [WORDSIZE-1:0]  num2_q, num2_d;
    logic                 op_q, op_d;
    logic                 issue_q, issue_d;
    logic                 busy_q, busy_d;

    logic [ENTRY_W-1:0]   head;
    logic [CW-1:0]        fifo_count;
    logic                 push, pop, have_req, load;

    // in_ready depends only on the registered count, never on this cycle's pop.
    assign in_ready = (fifo_count < FULL);
    assign push     = in_valid && in_ready;
    assign have_req = (fifo_count != '0);
    assign load     = have_req && ((state_q == IDLE) || (hold_cnt_q == '0));
    assign pop      = load;

    operand_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({in_num1, in_num2, in_operation}),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            op_q       <= 1'b0;
            issue_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            op_q       <= op_d;
            issue_q    <= issue_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (have_req) state_d = HOLD;
            HOLD: if ((hold_cnt_q == '0) && !have_req) state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        op_d       = op_q;
        issue_d    = 1'b0;
        busy_d     = busy_q;
        if (load) begin
            num1_d     = head[ENTRY_W-1 -: WORDSIZE];
            num2_d     = head[WORDSIZE:1];
            op_d       = head[0];
            hold_cnt_d = HOLD_LAST;
            issue_d    = 1'b1;
            busy_d     = 1'b1;
        end else if (state_q == HOLD) begin
            if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign num1          = num1_q;
    assign num2          = num2_q;
    assign operation_out = op_q;
    assign issue         = issue_q;
    assign busy          = busy_q;
    assign count         = fifo_count;

endmodule

// File: tb/tb_operand_issuer.sv
// Self-checking bench for operand_issuer: scenario tasks plus a scoreboard
// that compares every issued request against the order of acceptance.
module tb_operand_issuer;
    import processor_pkg::*;

    localparam int unsigned W     = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 7;

    typedef logic [2*W:0] entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_num1 = '0;
    logic [W-1:0]  in_num2 = '0;
    logic          in_operation = 1'b0;
    logic [W-1:0]  num1, num2;
    logic          operation_out, issue, busy;
    logic [2:0]    count;

    int            checks = 0;
    int            errors = 0;
    entry_t        exp_q[$];
    entry_t        sb_exp;
    entry_t        held = '0;
    int unsigned   issue_cyc_q[$];
    int unsigned   cyc = 0;
    int unsigned   issued = 0;
    bit            seen_dead = 1'b0;

    always #5 clk = ~clk;

    operand_issuer #(
        .WORDSIZE    (W),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_num1       (in_num1),
        .in_num2       (in_num2),
        .in_operation  (in_operation),
        .num1          (num1),
        .num2          (num2),
        .operation_out (operation_out),
        .issue         (issue),
        .busy          (busy),
        .count         (count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each issue pops the oldest accepted request; held value must not move.
    always @(negedge clk) begin
        if (!rst) begin
            if (num1 === 64'hDEAD) seen_dead = 1'b1;
            if (issue === 1'b1) begin
                issued++;
                issue_cyc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got=%h expected=<none>", {num1, num2, operation_out});
                end else begin
                    sb_exp = exp_q.pop_front();
                    if ({num1, num2, operation_out} !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_order got=%h expected=%h", {num1, num2, operation_out}, sb_exp);
                    end
                end
                held = {num1, num2, operation_out};
            end else if (busy === 1'b1) begin
                checks++;
                if ({num1, num2, operation_out} !== held) begin
                    errors++;
                    $display("FAIL hold_stable got=%h expected=%h", {num1, num2, operation_out}, held);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int unsigned n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_num1 = a;
        in_num2 = b;
        in_operation = op;
        do begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back({a, b, op});
        end else begin
            checks++;
            errors++;
            $display("FAIL push_timeout got=in_ready_low expected=accept num1=%h", a);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!(busy === 1'b0 && count === 3'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(busy === 1'b0 && count === 3'd0)) begin
            errors++;
            $display("FAIL drain_timeout got busy=%b count=%0d expected busy=0 count=0", busy, count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (num1 !== '0 || num2 !== '0 || operation_out !== 1'b0 || issue !== 1'b0 ||
                busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle got num1=%h num2=%h op=%b issue=%b busy=%b count=%0d in_ready=%b expected zeros and in_ready=1",
                         num1, num2, operation_out, issue, busy, count, in_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        push(64'd5, 64'd3, OP_ADD);
        @(negedge clk);
        checks++;
        if (count !== 3'd1 || issue !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_t got count=%0d issue=%b expected count=1 issue=0", count, issue);
        end
        @(negedge clk);
        checks++;
        if (issue !== 1'b1 || busy !== 1'b1 || count !== 3'd0 || num1 !== 64'd5 || num2 !== 64'd3 || operation_out !== 1'b0) begin
            errors++;
            $display("FAIL single_issue got issue=%b busy=%b count=%0d num1=%0d num2=%0d op=%b expected 1 1 0 5 3 0",
                     issue, busy, count, num1, num2, operation_out);
        end
        for (int i = 1; i < HOLD; i++) begin
            @(negedge clk);
            checks++;
            if (issue !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_window cycle=%0d got issue=%b busy=%b expected issue=0 busy=1", i, issue, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || issue !== 1'b0 || num1 !== 64'd5 || num2 !== 64'd3 || operation_out !== 1'b0) begin
            errors++;
            $display("FAIL single_retain got busy=%b issue=%b num1=%0d num2=%0d op=%b expected 0 0 5 3 0",
                     busy, issue, num1, num2, operation_out);
        end
        wait_idle();
    endtask

    task automatic test_burst();
        bit saw_full = 1'b0;
        int unsigned base = issued;
        int unsigned n = 0;
        issue_cyc_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(64'(i + 1), 64'((i + 1) * 10), i[0]);
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== (count < 3'd4)) begin
                        errors++;
                        $display("FAIL burst_ready got in_ready=%b count=%0d expected in_ready=%b",
                                 in_ready, count, (count < 3'd4));
                    end
                    if (count === 3'd4 && in_ready === 1'b0) saw_full = 1'b1;
                end
            end
        join
        checks++;
        if (!saw_full) begin
            errors++;
            $display("FAIL burst_full got no full state expected count=4 with in_ready=0");
        end
        while (issued - base < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (issued - base != 6 || issue_cyc_q.size() < 6) begin
            errors++;
            $display("FAIL burst_issued got=%0d expected=6", issued - base);
        end else begin
            for (int k = 1; k < 6; k++) begin
                checks++;
                if (issue_cyc_q[k] - issue_cyc_q[k-1] != HOLD) begin
                    errors++;
                    $display("FAIL burst_spacing idx=%0d got=%0d expected=%0d",
                             k, issue_cyc_q[k] - issue_cyc_q[k-1], HOLD);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_full_ignore();
        seen_dead = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(64'(100 + i), 64'(200 + i), OP_SUB);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready);
        end
        in_valid = 1'b1;
        in_num1 = 64'hDEAD;
        in_num2 = 64'hBEEF;
        in_operation = OP_ADD;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_ignored_count got=%0d expected=4", count);
        end
        wait_idle();
        checks++;
        if (seen_dead) begin
            errors++;
            $display("FAIL full_dead_seen got num1=0xdead expected never");
        end
    endtask

    task automatic test_simul();
        push(64'h11, 64'h21, OP_ADD);
        push(64'h12, 64'h22, OP_SUB);
        push(64'h13, 64'h23, OP_ADD);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_num1 = 64'h14;
        in_num2 = 64'h24;
        in_operation = OP_SUB;
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || issue !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre got count=%0d issue=%b in_ready=%b expected 2 0 1", count, issue, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({64'h14, 64'h24, OP_SUB});
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || issue !== 1'b1) begin
            errors++;
            $display("FAIL simul_post got count=%0d issue=%b expected count=2 issue=1", count, issue);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        push(64'h31, 64'h41, OP_ADD);
        push(64'h32, 64'h42, OP_SUB);
        push(64'h33, 64'h43, OP_ADD);
        push(64'h34, 64'h44, OP_SUB);
        #1;
        checks++;
        if (count !== 3'd3 || busy !== 1'b1 || num1 !== 64'h31) begin
            errors++;
            $display("FAIL arst_setup got count=%0d busy=%b num1=%h expected 3 1 31", count, busy, num1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (num1 !== '0 || num2 !== '0 || operation_out !== 1'b0 || issue !== 1'b0 ||
            busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_immediate got num1=%h num2=%h op=%b issue=%b busy=%b count=%0d in_ready=%b expected zeros and in_ready=1",
                     num1, num2, operation_out, issue, busy, count, in_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(64'h55, 64'h66, OP_SUB);
        @(negedge clk);
        checks++;
        if (count !== 3'd1 || issue !== 1'b0) begin
            errors++;
            $display("FAIL arst_relatency_t got count=%0d issue=%b expected count=1 issue=0", count, issue);
        end
        @(negedge clk);
        checks++;
        if (issue !== 1'b1 || num1 !== 64'h55 || num2 !== 64'h66 || operation_out !== 1'b1) begin
            errors++;
            $display("FAIL arst_reissue got issue=%b num1=%h num2=%h op=%b expected 1 55 66 1",
                     issue, num1, num2, operation_out);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_ignore();
        test_simul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
